uart_rx_param: RTL and testbench
================================

Name: uart_rx_param

Overview:
Parametrised UART receiver with oversampled, mid-bit sampling. Supports configurable data width, parity (none/even/odd) and 1 or 2 stop bits. Reports parity, framing and overrun errors and delivers words through a valid/ready output register. Sits between the pad-side rx line and the UART register/FIFO layer.

Parameters:
DATA_W, 8, data bits per frame; legal 5..9.
OVS, 16, oversample ticks per bit; even, >=4.
DIV_W, 16, width of baud_div.

Ports:
clk  in  1  system clock; all logic is on the rising edge.
reset  in  1  synchronous, active-high reset.
rx_en  in  1  allows a new frame to start; sampled only in IDLE.
rx  in  1  asynchronous serial line; idles high.
baud_div  in  DIV_W  clk cycles per oversample tick; 0 is treated as 1.
parity_mode  in  2  00 none, 01 even, 10 odd, 11 reserved (treated as none).
stop2  in  1  0: one stop bit; 1: two stop bits.
data_out  out  DATA_W  received word, LSB = first data bit.
out_valid  out  1  data_out and error flags are valid.
out_ready  in  1  consumer accepts the word.
parity_err  out  1  parity mismatch for the held word.
frame_err  out  1  a sampled stop bit was 0 for the held word.
overrun  out  1  sticky: a completed frame was dropped.
busy  out  1  FSM is not in IDLE.

Behaviour:
- Reset values: data_out=0, out_valid=0, parity_err=0, frame_err=0, overrun=0, busy=0. State=IDLE. Synchroniser flops=1.
- rx passes through a 2-flop synchroniser; rx_s is the synchronised value.
- Tick generator: counter runs 0..baud_div-1 and pulses tick on the terminal count. It is cleared on start detection, so the first tick lands baud_div cycles later.
- Sample counter counts ticks 0..OVS-1 within each bit. The sample point is tick index OVS/2-1 (bit centre).
- FSM states and transitions:
  - IDLE: on rx_en && falling edge of rx_s (previous rx_s=1, current rx_s=0), go to START.
  - START: at the sample point, rx_s=1 means a false start: return to IDLE with no output. rx_s=0 means go to DATA at the end of the bit.
  - DATA: take DATA_W samples, LSB first. Go to PARITY if parity is enabled, else STOP.
  - PARITY: take one sample. Even mode: error if XOR of data and parity bit is 1. Odd mode: error if it is 0.
  - STOP: take 1 or 2 (stop2) samples. Any sampled 0 sets frame_err for this frame. Leave for IDLE on the cycle after the last stop sample, not at bit end, so the receiver can resync on the next start edge.
- Delivery: on the cycle after the last stop sample, load data_out, parity_err and frame_err, and set out_valid.
- Handshake: out_valid stays high until the cycle where out_valid && out_ready; it clears on the following cycle. data_out and the flags are stable while out_valid=1.
- Simultaneous handshake and new completion: the new word loads, out_valid stays 1, and overrun is not set.
- Completion while out_valid=1 with no handshake: the new frame is dropped, held data is untouched, and overrun is set. overrun clears only on reset or on the next accepted handshake.
- Deasserting rx_en mid-frame does not abort the frame.
- Changing baud_div, parity_mode or stop2 mid-frame gives undefined results for that frame only.
- Reset mid-frame returns to the reset state immediately, and any partial word is discarded.

Optional Feature:
UART_RX_MAJORITY_EN:
- Defined: every sample (start, data, parity, stop) is the 2-of-3 majority of rx_s at tick indices OVS/2-2, OVS/2-1 and OVS/2. The decision is taken at tick OVS/2.
- Undefined: each sample is the single value of rx_s at tick OVS/2-1.
- Port list and delivery cycle are identical in both builds.

Decomposition:
- Package uart_pkg holds:
  - enum rx_state_t {IDLE, START, DATA, PARITY, STOP};
  - enum parity_mode_t {PAR_NONE=0, PAR_EVEN=1, PAR_ODD=2};
  - localparam helpers for sample-point indices.
- Sub-module uart_baud_tick holds the divider and tick output, with a clear input. The same block is reusable by the transmitter.

Test Plan:
1. DATA_W=8, OVS=16, baud_div=4, no parity, stop2=0; send 0xA5 -> out_valid rises 1 cycle after the mid stop sample; data_out=0xA5; all error flags 0.
2. Even parity; send 0x3C with parity bit 1 -> data_out=0x3C, parity_err=1. Resend with parity bit 0 -> parity_err=0.
3. stop2=1, second stop bit driven 0 -> frame_err=1 and out_valid=1. The next clean frame 0x0F has frame_err=0.
4. rx low for 3 oversample ticks, then high (false start) -> no out_valid, busy returns to 0, and the next frame 0x81 is received correctly.
5. out_ready=0; send 0x11 then 0x22 -> data_out stays 0x11 and overrun=1. Raise out_ready for one handshake -> out_valid=0 and overrun=0.
6. Assert reset at data bit 4 of a frame -> next cycle out_valid=0 and busy=0. A following frame 0x5A is received intact. With UART_RX_MAJORITY_EN, a 1-clk glitch at a data-bit centre (baud_div=4) does not corrupt 0x5A.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and sample-point helpers for the UART receiver/transmitter blocks.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_mode_t;

  // Tick index of the bit centre (single-sample decision point).
  function automatic int samp_idx(input int ovs);
    return ovs / 2 - 1;
  endfunction

  // First vote of the 3-sample majority window.
  function automatic int maj_lo_idx(input int ovs);
    return ovs / 2 - 2;
  endfunction

  // Last vote of the majority window; the majority decision is taken here.
  function automatic int maj_hi_idx(input int ovs);
    return ovs / 2;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle tick every baud_div clocks (0 acts as 1).
// The clear input restarts the count so the first tick lands baud_div cycles later.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic [DIV_W-1:0] baud_div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] term;

  assign term = (baud_div == '0) ? '0 : baud_div - DIV_W'(1);
  // A count beyond a freshly lowered terminal value also wraps instead of running away.
  assign tick = !clear && (cnt >= term);

  // Divider counter, restarted on clear and on every tick.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (cnt >= term) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised oversampling UART receiver with valid/ready output register.
// Build option UART_RX_MAJORITY_EN: each bit is the 2-of-3 majority of the
// samples around the bit centre instead of a single centre sample.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int OVS    = 16,
  parameter int DIV_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_en,
  input  logic              rx,
  input  logic [DIV_W-1:0]  baud_div,
  input  logic [1:0]        parity_mode,
  input  logic              stop2,
  output logic [DATA_W-1:0] data_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              parity_err,
  output logic              frame_err,
  output logic              overrun,
  output logic              busy
);

  localparam int SW = $clog2(OVS);
  localparam int BW = $clog2(DATA_W + 1);
  localparam logic [SW-1:0] LAST_TICK = SW'(OVS - 1);
`ifdef UART_RX_MAJORITY_EN
  localparam logic [SW-1:0] M0_TICK  = SW'(maj_lo_idx(OVS));
  localparam logic [SW-1:0] M1_TICK  = SW'(samp_idx(OVS));
  localparam logic [SW-1:0] DEC_TICK = SW'(maj_hi_idx(OVS));
`else
  localparam logic [SW-1:0] DEC_TICK = SW'(samp_idx(OVS));
`endif

  rx_state_t         state, state_nx;
  logic              rx_m, rx_s, rx_prev;
  logic              tick, clear;
  logic [SW-1:0]     scnt;
  logic              samp_stb, samp_val, bit_end;
  logic              start_det, done, last_stop, par_en, hs;
  logic [DATA_W-1:0] shreg;
  logic [BW-1:0]     bit_cnt;
  logic              par_acc, ferr, stop_cnt;
  logic              par_err_new, frm_err_new;

  // Two-flop synchroniser plus one delayed copy for falling-edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_m    <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_m    <= rx;
      rx_s    <= rx_m;
      rx_prev <= rx_s;
    end
  end

  // Divider is held cleared while idle, so counting starts on the start edge.
  assign clear = (state == IDLE);

  uart_baud_tick #(.DIV_W(DIV_W)) u_tick (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear),
    .baud_div (baud_div),
    .tick     (tick)
  );

  // Oversample position within the current bit.
  always_ff @(posedge clk) begin
    if (reset || state == IDLE) begin
      scnt <= '0;
    end else if (tick) begin
      scnt <= (scnt == LAST_TICK) ? '0 : scnt + SW'(1);
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic m0, m1;

  // Capture the two earlier votes; the third is rx_s at the decision tick.
  always_ff @(posedge clk) begin
    if (tick && scnt == M0_TICK) m0 <= rx_s;
    if (tick && scnt == M1_TICK) m1 <= rx_s;
  end

  assign samp_val = (m0 & m1) | (m0 & rx_s) | (m1 & rx_s);
`else
  assign samp_val = rx_s;
`endif

  assign samp_stb    = tick && (scnt == DEC_TICK);
  assign bit_end     = tick && (scnt == LAST_TICK);
  assign start_det   = rx_en && rx_prev && !rx_s;
  assign par_en      = (parity_mode == PAR_EVEN) || (parity_mode == PAR_ODD);
  assign last_stop   = (stop_cnt == stop2);
  assign hs          = out_valid && out_ready;
  assign par_err_new = (parity_mode == PAR_EVEN) ? par_acc :
                       (parity_mode == PAR_ODD)  ? ~par_acc : 1'b0;
  assign frm_err_new = ferr | ~samp_val;

  // Receiver state register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state logic; STOP exits right after its last sample to allow fast resync.
  always_comb begin
    state_nx = state;
    done     = 1'b0;
    busy     = (state != IDLE);
    case (state)
      IDLE:    if (start_det) state_nx = START;
      START: begin
        if (samp_stb && samp_val) state_nx = IDLE;
        else if (bit_end)         state_nx = DATA;
      end
      DATA:    if (bit_end && bit_cnt == BW'(DATA_W)) state_nx = par_en ? PARITY : STOP;
      PARITY:  if (bit_end) state_nx = STOP;
      STOP: begin
        if (samp_stb && last_stop) begin
          state_nx = IDLE;
          done     = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Per-frame bookkeeping: bit count, running parity, stop-bit count and framing flag.
  always_ff @(posedge clk) begin
    if (reset || state == IDLE) begin
      bit_cnt  <= '0;
      par_acc  <= 1'b0;
      stop_cnt <= 1'b0;
      ferr     <= 1'b0;
    end else if (samp_stb) begin
      case (state)
        DATA: begin
          bit_cnt <= bit_cnt + BW'(1);
          par_acc <= par_acc ^ samp_val;
        end
        PARITY: par_acc <= par_acc ^ samp_val;
        STOP: begin
          stop_cnt <= 1'b1;
          ferr     <= ferr | ~samp_val;
        end
        default: ;
      endcase
    end
  end

  // Data shifter: bits enter at the MSB so the first bit ends up as the LSB.
  always_ff @(posedge clk) begin
    if (state == DATA && samp_stb) shreg <= {samp_val, shreg[DATA_W-1:1]};
  end

  // Output register: loads when empty or being emptied, otherwise drops and flags overrun.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_out   <= '0;
      out_valid  <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (done && (!out_valid || out_ready)) begin
        data_out   <= shreg;
        parity_err <= par_err_new;
        frame_err  <= frm_err_new;
        out_valid  <= 1'b1;
      end else if (hs) begin
        out_valid  <= 1'b0;
      end
      if (hs)                   overrun <= 1'b0;
      else if (done && out_valid) overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed + randomized bench for uart_rx_param (DATA_W=8, OVS=16, baud_div=4).
module tb_uart_rx_param;

  localparam int DATA_W = 8;
  localparam int OVS    = 16;
  localparam int DIV_W  = 16;
  localparam int DIV    = 4;
  localparam int BITC   = OVS * DIV;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              rx_en = 1'b0;
  logic              rx = 1'b1;
  logic [DIV_W-1:0]  baud_div = DIV_W'(DIV);
  logic [1:0]        parity_mode = 2'd0;
  logic              stop2 = 1'b0;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] data_out;
  logic              out_valid, parity_err, frame_err, overrun, busy;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   rise_cyc = -1;
  int   start_cyc = 0;
  logic ov_q = 1'b0;

  logic [7:0] rd;
  logic [1:0] rpm;
  logic       rpb, rst2, rs1, rs2;

  uart_rx_param #(.DATA_W(DATA_W), .OVS(OVS), .DIV_W(DIV_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_en       (rx_en),
    .rx          (rx),
    .baud_div    (baud_div),
    .parity_mode (parity_mode),
    .stop2       (stop2),
    .data_out    (data_out),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .parity_err  (parity_err),
    .frame_err   (frame_err),
    .overrun     (overrun),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Remember the cycle at which out_valid last rose.
  always @(negedge clk) begin
    if (out_valid && !ov_q) rise_cyc <= cyc;
    ov_q <= out_valid;
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
    n_cmp++;
    assert (obs >= lo && obs <= hi) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  // Reference parity rule: even mode errs on an odd count of ones, odd mode on an even count.
  function automatic logic exp_perr(input logic [7:0] d, input logic [1:0] pm, input logic p);
    int ones;
    ones = $countones(d) + int'(p);
    if (pm == 2'd1) return (ones % 2) == 1;
    if (pm == 2'd2) return (ones % 2) == 0;
    return 1'b0;
  endfunction

  // Hold one bit for a full bit period; optionally invert it for one clock at offset goff.
  task automatic drive_bit(input logic b, input int goff);
    for (int c = 0; c < BITC; c++) begin
      rx = (c == goff) ? ~b : b;
      @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic [1:0] pm, input logic pbit,
                            input logic st2, input logic s1, input logic s2, input int gbit);
    parity_mode = pm;
    stop2       = st2;
    start_cyc   = cyc;
    drive_bit(1'b0, -1);
    for (int i = 0; i < 8; i++) drive_bit(d[i], (i == gbit) ? BITC / 2 : -1);
    if (pm == 2'd1 || pm == 2'd2) drive_bit(pbit, -1);
    drive_bit(s1, -1);
    if (st2) drive_bit(s2, -1);
    drive_bit(1'b1, -1);
  endtask

  // Send a frame into an empty output register and check the delivered word.
  task automatic rx_frame(input string tag, input logic [7:0] d, input logic [1:0] pm,
                          input logic pbit, input logic st2, input logic s1, input logic s2,
                          input int gbit);
    int nbits, mid;
    send_frame(d, pm, pbit, st2, s1, s2, gbit);
    nbits = 1 + 8 + ((pm == 2'd1 || pm == 2'd2) ? 1 : 0) + 1 + (st2 ? 1 : 0);
    mid   = nbits * BITC - BITC / 2;
    chk_rng({tag, "_latency"}, rise_cyc - start_cyc, mid, mid + 8);
    chk1({tag, "_valid"}, out_valid, 1'b1);
    chk8({tag, "_data"}, data_out, d);
    chk1({tag, "_perr"}, parity_err, exp_perr(d, pm, pbit));
    chk1({tag, "_ferr"}, frame_err, !(s1 && (st2 ? s2 : 1'b1)));
    chk1({tag, "_ovr"}, overrun, 1'b0);
  endtask

  task automatic accept(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk1({tag, "_acc_valid"}, out_valid, 1'b0);
    chk1({tag, "_acc_ovr"}, overrun, 1'b0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk8("rst_data", data_out, 8'h00);
    chk1("rst_valid", out_valid, 1'b0);
    chk1("rst_perr", parity_err, 1'b0);
    chk1("rst_ferr", frame_err, 1'b0);
    chk1("rst_ovr", overrun, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    reset = 1'b0;
    rx_en = 1'b1;
    repeat (BITC) @(negedge clk);

    // Plain 8N1 frame.
    rx_frame("t1", 8'hA5, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, -1);
    accept("t1");

    // Even parity, bad then good parity bit.
    rx_frame("t2a", 8'h3C, 2'd1, 1'b1, 1'b0, 1'b1, 1'b1, -1);
    accept("t2a");
    rx_frame("t2b", 8'h3C, 2'd1, 1'b0, 1'b0, 1'b1, 1'b1, -1);
    accept("t2b");

    // Two stop bits, second one low, then a clean frame.
    rx_frame("t3a", 8'h55, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, -1);
    accept("t3a");
    rx_frame("t3b", 8'h0F, 2'd0, 1'b0, 1'b1, 1'b1, 1'b1, -1);
    accept("t3b");

    // False start: line low for 3 oversample ticks only.
    parity_mode = 2'd0;
    stop2       = 1'b0;
    rx = 1'b0;
    repeat (8) @(negedge clk);
    chk1("t4_busy_hi", busy, 1'b1);
    repeat (3 * DIV - 8) @(negedge clk);
    rx = 1'b1;
    repeat (BITC) @(negedge clk);
    chk1("t4_busy_lo", busy, 1'b0);
    chk1("t4_no_valid", out_valid, 1'b0);
    rx_frame("t4", 8'h81, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, -1);
    accept("t4");

    // Overrun: second word dropped while the first is held.
    rx_frame("t5", 8'h11, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, -1);
    send_frame(8'h22, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, -1);
    chk1("t5_valid_held", out_valid, 1'b1);
    chk8("t5_data_held", data_out, 8'h11);
    chk1("t5_ovr_set", overrun, 1'b1);
    accept("t5");

    // Randomized frames against the reference rules.
    for (int k = 0; k < 10; k++) begin
      rd   = 8'($urandom);
      rpm  = 2'($urandom_range(0, 3));
      rpb  = 1'($urandom_range(0, 1));
      rst2 = 1'($urandom_range(0, 1));
      rs1  = ($urandom_range(0, 3) != 0);
      rs2  = ($urandom_range(0, 3) != 0);
      rx_frame("rnd", rd, rpm, rpb, rst2, rs1, rs2, -1);
      accept("rnd");
    end

    // Reset in the middle of data bit 4 while a word is still held.
    send_frame(8'h99, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, -1);
    chk1("t6_pre_valid", out_valid, 1'b1);
    rd = 8'hC3;
    drive_bit(1'b0, -1);
    for (int i = 0; i < 4; i++) drive_bit(rd[i], -1);
    rx = rd[4];
    repeat (BITC / 2) @(negedge clk);
    chk1("t6_busy_mid", busy, 1'b1);
    rx_en = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk1("t6_rst_valid", out_valid, 1'b0);
    chk1("t6_rst_busy", busy, 1'b0);
    chk8("t6_rst_data", data_out, 8'h00);
    chk1("t6_rst_ovr", overrun, 1'b0);
    repeat (BITC / 2 - 1) @(negedge clk);
    for (int i = 5; i < 8; i++) drive_bit(rd[i], -1);
    drive_bit(1'b1, -1);
    drive_bit(1'b1, -1);
    rx_en = 1'b1;
    rx_frame("t6", 8'h5A, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, -1);
    accept("t6");

`ifdef UART_RX_MAJORITY_EN
    // One-clock glitch at the centre of data bit 3 is outvoted.
    rx_frame("t6g", 8'h5A, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 3);
    accept("t6g");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
